seventap_coeff_ctrl: RTL and testbench
======================================

Name: seventap_coeff_ctrl

Overview:
Coefficient sequencer for one seven-tap systolic preadd FIR.
- Holds a writable shadow bank of seven 18-bit coefficients and an active bank that drives the filter's coeff0..coeff6 inputs.
- Swaps shadow into active atomically on commit, then blanks output-valid for the filter pipeline depth so no sample mixing old and new coefficients is marked valid.
- Sits between the register/control interface and the filter instance.

Parameters:
FLUSH_CYCLES, 12, cycles dat_valid_o stays low after a swap (filter latency from coeff change to clean output); legal range 1..255.
INIT_COEFF, 126'd0, reset value of both banks, packed {c6,...,c0}, 18 bits each.

Ports:
clk_i  input  1  filter clock
rst_i  input  1  asynchronous active-high reset
wr_addr_i  input  3  shadow coefficient index 0..6
wr_dat_i  input  18  coefficient value
wr_valid_i  input  1  write request
wr_ready_o  output  1  write accepted when wr_valid_i&&wr_ready_o
commit_i  input  1  request swap of shadow into active
commit_ack_o  output  1  one-cycle pulse when flush after swap completes
busy_o  output  1  high in SWAP or FLUSH
err_o  output  1  sticky: write to address 7 occurred; cleared on accepted commit
dat_valid_o  output  1  filter output qualifier
coeff0_o..coeff6_o  output  18 each  active coefficients to the filter

Behaviour:
- Reset (async assert, sync release):
  - shadow = active = INIT_COEFF; err_o=0, commit_ack_o=0, dat_valid_o=0.
  - State FLUSH with counter=FLUSH_CYCLES, so busy_o=1 and wr_ready_o=0 out of reset.
- States:
  - IDLE: wr_ready_o=1, busy_o=0, dat_valid_o=1.
    - Accepted write updates shadow[wr_addr_i] at next edge.
    - commit_i=1 -> SWAP.
  - SWAP (1 cycle): active <= shadow; wr_ready_o=0, busy_o=1, dat_valid_o=0; counter <= FLUSH_CYCLES; -> FLUSH.
  - FLUSH: wr_ready_o=0, busy_o=1, dat_valid_o=0; counter decrements each cycle.
    - On counter==1: -> IDLE, with commit_ack_o=1 for exactly that cycle (suppressed for the post-reset flush).
- coeffN_o are registered outputs of the active bank; they change only on the SWAP edge.
- Commit takes 1+FLUSH_CYCLES cycles from the accepting edge to the first dat_valid_o=1.
- Simultaneous write and commit in IDLE:
  - The write is merged, and active receives the shadow including the new value.
  - Address-7 writes set err_o, and that same commit clears it (the clear wins).
- Address 7 write: data discarded, err_o set; handshake still completes.
- commit_i in SWAP or FLUSH is ignored, not queued; commit_i held high re-triggers on return to IDLE.
- rst_i asserted mid-FLUSH or mid-SWAP:
  - Both banks return to INIT_COEFF.
  - Any shadow edits are lost.
  - No commit_ack_o is issued.
- No combinational path from inputs to any output.

Optional Feature:
SEVENTAP_COEFF_SYMMETRIC_EN
- Defined: symmetric-filter mode.
  - A write to address k in 0..3 updates shadow[k] and shadow[6-k] in the same cycle; address 3 writes once.
  - Writes to addresses 4..7 are discarded and set err_o.
  - Active bank is therefore always symmetric.
- Undefined: all seven addresses are independent; only address 7 is an error.

Test Plan:
- Reset release with INIT_COEFF=0 -> busy_o=1 for exactly 12 cycles, then dat_valid_o=1, wr_ready_o=1, commit_ack_o never pulses, all coeffN_o=0.
- Write addr0..6 = 18'h00100..18'h00106, commit one cycle later -> coeffN_o unchanged until the SWAP edge, then equal to the written values; dat_valid_o low for 13 cycles; commit_ack_o pulses once on cycle 13.
- In IDLE, write addr2=18'h3FFFF in the same cycle as commit_i -> coeff2_o=18'h3FFFF after the swap.
- Write addr7=18'h12345 -> err_o=1, no shadow change. Next commit -> err_o=0 at its accepting edge. Writes attempted during FLUSH see wr_ready_o=0 and are not accepted.
- Assert rst_i 5 cycles into FLUSH after committing nonzero values -> coeffN_o back to INIT_COEFF immediately; full 12-cycle flush restarts; no commit_ack_o.
- SEVENTAP_COEFF_SYMMETRIC_EN defined: write addr1=18'h00ABC -> after commit, coeff1_o=coeff5_o=18'h00ABC. Write addr5 -> err_o=1, shadow unchanged.

Source files
------------

// File: rtl/seventap_coeff_ctrl.sv
// Coefficient sequencer for a seven-tap systolic preadd FIR: shadow/active banks, atomic swap, output blanking.
// Optional symmetric-filter write mode is enabled by defining SEVENTAP_COEFF_SYMMETRIC_EN.
module seventap_coeff_ctrl #(
    parameter int unsigned   FLUSH_CYCLES = 12,
    parameter logic [125:0]  INIT_COEFF   = 126'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  wr_addr_i,
    input  logic [17:0] wr_dat_i,
    input  logic        wr_valid_i,
    output logic        wr_ready_o,
    input  logic        commit_i,
    output logic        commit_ack_o,
    output logic        busy_o,
    output logic        err_o,
    output logic        dat_valid_o,
    output logic [17:0] coeff0_o,
    output logic [17:0] coeff1_o,
    output logic [17:0] coeff2_o,
    output logic [17:0] coeff3_o,
    output logic [17:0] coeff4_o,
    output logic [17:0] coeff5_o,
    output logic [17:0] coeff6_o
);

    typedef enum logic [1:0] {IDLE, SWAP, FLUSH} state_t;

    localparam logic [7:0] FLUSH_LOAD = 8'(FLUSH_CYCLES);

    state_t      state, state_nxt;
    logic [7:0]  count;
    logic        ack_armed;
    logic [17:0] shadow [7];
    logic [17:0] active [7];
    logic [6:0]  wr_hit;
    logic        wr_bad;
    logic        accept_wr;
    logic        accept_commit;

    assign accept_wr     = (state == IDLE) && wr_valid_i;
    assign accept_commit = (state == IDLE) && commit_i;

    // Decode which shadow slots a write touches and whether the address is illegal.
    always_comb begin
        wr_hit = '0;
        wr_bad = 1'b0;
`ifdef SEVENTAP_COEFF_SYMMETRIC_EN
        wr_bad = (wr_addr_i > 3'd3);
        for (int i = 0; i < 7; i++) begin
            if (!wr_bad && (wr_addr_i == 3'(i) || wr_addr_i == 3'(6 - i)))
                wr_hit[i] = 1'b1;
        end
`else
        wr_bad = (wr_addr_i == 3'd7);
        for (int i = 0; i < 7; i++) begin
            if (wr_addr_i == 3'(i))
                wr_hit[i] = 1'b1;
        end
`endif
    end

    always_comb begin
        state_nxt   = state;
        wr_ready_o  = 1'b0;
        busy_o      = 1'b1;
        dat_valid_o = 1'b0;
        case (state)
            IDLE: begin
                wr_ready_o  = 1'b1;
                busy_o      = 1'b0;
                dat_valid_o = 1'b1;
                if (commit_i)
                    state_nxt = SWAP;
            end
            SWAP:    state_nxt = FLUSH;
            FLUSH:   if (count == 8'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Reset lands in FLUSH so the filter pipeline drains before the first valid output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= FLUSH;
            count     <= FLUSH_LOAD;
            ack_armed <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == SWAP) begin
                count     <= FLUSH_LOAD;
                ack_armed <= 1'b1;
            end else if (state == FLUSH) begin
                count <= count - 8'd1;
                if (count == 8'd1)
                    ack_armed <= 1'b0;
            end
        end
    end

    // A write and a commit in the same IDLE cycle both land here, so the swap sees the merged bank.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 7; i++) begin
                shadow[i] <= INIT_COEFF[18*i +: 18];
                active[i] <= INIT_COEFF[18*i +: 18];
            end
            err_o <= 1'b0;
        end else begin
            if (accept_wr) begin
                for (int i = 0; i < 7; i++) begin
                    if (wr_hit[i])
                        shadow[i] <= wr_dat_i;
                end
            end
            if (state == SWAP) begin
                for (int i = 0; i < 7; i++)
                    active[i] <= shadow[i];
            end
            if (accept_commit)
                err_o <= 1'b0;
            else if (accept_wr && wr_bad)
                err_o <= 1'b1;
        end
    end

    assign commit_ack_o = (state == FLUSH) && (count == 8'd1) && ack_armed;

    assign coeff0_o = active[0];
    assign coeff1_o = active[1];
    assign coeff2_o = active[2];
    assign coeff3_o = active[3];
    assign coeff4_o = active[4];
    assign coeff5_o = active[5];
    assign coeff6_o = active[6];

endmodule

// File: tb/tb_seventap_coeff_ctrl.sv
// Self-checking bench for seventap_coeff_ctrl with a cycle-level behavioural model of the bank/blanking rules.
module tb_seventap_coeff_ctrl;

    localparam int FLUSH = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  wr_addr = '0;
    logic [17:0] wr_dat = '0;
    logic        wr_valid = 1'b0;
    logic        commit = 1'b0;
    logic        wr_ready, commit_ack, busy, err, dat_valid;
    logic [17:0] c0, c1, c2, c3, c4, c5, c6;
    logic [17:0] dut_coeff [7];

    int tests_run = 0;
    int tests_failed = 0;

    logic [17:0] m_shadow [7];
    logic [17:0] m_active [7];
    int          m_blank;
    bit          m_err, m_swap_pending, m_ack_armed;

    seventap_coeff_ctrl #(.FLUSH_CYCLES(FLUSH), .INIT_COEFF(126'd0)) dut (
        .clk_i(clk), .rst_i(rst),
        .wr_addr_i(wr_addr), .wr_dat_i(wr_dat), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
        .commit_i(commit), .commit_ack_o(commit_ack), .busy_o(busy), .err_o(err),
        .dat_valid_o(dat_valid),
        .coeff0_o(c0), .coeff1_o(c1), .coeff2_o(c2), .coeff3_o(c3),
        .coeff4_o(c4), .coeff5_o(c5), .coeff6_o(c6)
    );

    assign dut_coeff[0] = c0;
    assign dut_coeff[1] = c1;
    assign dut_coeff[2] = c2;
    assign dut_coeff[3] = c3;
    assign dut_coeff[4] = c4;
    assign dut_coeff[5] = c5;
    assign dut_coeff[6] = c6;

    always #5 clk = ~clk;

    // m_blank counts cycles still to run before dat_valid returns; zero means idle.
    task automatic model_reset();
        for (int i = 0; i < 7; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
        m_err = 1'b0;
        m_blank = FLUSH;
        m_swap_pending = 1'b0;
        m_ack_armed = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [2:0] a, input logic [17:0] d, input logic c);
        if (m_blank == 0) begin
            if (v) begin
`ifdef SEVENTAP_COEFF_SYMMETRIC_EN
                if (a <= 3'd3) begin
                    m_shadow[int'(a)] = d;
                    m_shadow[6 - int'(a)] = d;
                end else
                    m_err = 1'b1;
`else
                if (a != 3'd7) m_shadow[int'(a)] = d;
                else m_err = 1'b1;
`endif
            end
            if (c) begin
                m_err = 1'b0;
                m_blank = 1 + FLUSH;
                m_swap_pending = 1'b1;
                m_ack_armed = 1'b1;
            end
        end else begin
            if (m_swap_pending) begin
                for (int i = 0; i < 7; i++) m_active[i] = m_shadow[i];
                m_swap_pending = 1'b0;
            end
            m_blank--;
            if (m_blank == 0) m_ack_armed = 1'b0;
        end
    endtask

    // Called at a negedge: drive inputs, advance one clock edge, return at the next negedge.
    task automatic tick(input logic v, input logic [2:0] a, input logic [17:0] d, input logic c);
        wr_valid = v;
        wr_addr  = a;
        wr_dat   = d;
        commit   = c;
        @(posedge clk);
        model_step(v, a, d, c);
        @(negedge clk);
        wr_valid = 1'b0;
        commit   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int ack_seen = 0;
        do_reset();
        for (int i = 0; i < FLUSH; i++) begin
            tests_run++;
            if (busy !== 1'b1 || dat_valid !== 1'b0 || wr_ready !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_busy cycle %0d: busy=%b valid=%b ready=%b, required 1/0/0", i, busy, dat_valid, wr_ready);
            end
            if (commit_ack === 1'b1) ack_seen++;
            tick(1'b0, 3'd0, 18'd0, 1'b0);
        end
        tests_run++;
        if (busy !== 1'b0 || dat_valid !== 1'b1 || wr_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_idle: busy=%b valid=%b ready=%b, required 0/1/1", busy, dat_valid, wr_ready);
        end
        tests_run++;
        if (ack_seen != 0 || {c0, c1, c2, c3, c4, c5, c6} !== 126'd0 || err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_values: acks=%0d coeffs=%h err=%b, required 0/0/0", ack_seen, {c6, c5, c4, c3, c2, c1, c0}, err);
        end
    endtask

    task automatic test_write_commit();
        int low_count = 0, ack_count = 0, ack_cycle = 0;
        bit bad;
        for (int i = 0; i < 7; i++) tick(1'b1, 3'(i), 18'h00100 + 18'(i), 1'b0);
        tick(1'b0, 3'd0, 18'd0, 1'b0);
        tick(1'b0, 3'd0, 18'd0, 1'b1);
        for (int cyc = 1; cyc <= 14; cyc++) begin
            if (dat_valid !== 1'b1) low_count++;
            if (commit_ack === 1'b1) begin
                ack_count++;
                ack_cycle = cyc;
            end
            if (cyc == 1 || cyc == 2) begin
                bad = 1'b0;
                for (int i = 0; i < 7; i++) if (dut_coeff[i] !== m_active[i]) bad = 1'b1;
                tests_run++;
                if (bad) begin
                    tests_failed++;
                    $display("[TB] FAIL commit_coeff cycle %0d: got %h, required %h", cyc,
                             {c6, c5, c4, c3, c2, c1, c0},
                             {m_active[6], m_active[5], m_active[4], m_active[3], m_active[2], m_active[1], m_active[0]});
                end
            end
            tick(1'b0, 3'd0, 18'd0, 1'b0);
        end
`ifndef SEVENTAP_COEFF_SYMMETRIC_EN
        tests_run++;
        if (c3 !== 18'h00103 || c6 !== 18'h00106) begin
            tests_failed++;
            $display("[TB] FAIL commit_values: c3=%h c6=%h, required 00103/00106", c3, c6);
        end
`endif
        tests_run++;
        if (low_count != 1 + FLUSH || ack_count != 1 || ack_cycle != 1 + FLUSH) begin
            tests_failed++;
            $display("[TB] FAIL commit_timing: low=%0d acks=%0d ack_cycle=%0d, required %0d/1/%0d",
                     low_count, ack_count, ack_cycle, 1 + FLUSH, 1 + FLUSH);
        end
    endtask

    task automatic test_merge();
        tick(1'b1, 3'd2, 18'h3FFFF, 1'b1);
        for (int i = 0; i < 1 + FLUSH; i++) tick(1'b0, 3'd0, 18'd0, 1'b0);
        tests_run++;
        if (c2 !== 18'h3FFFF || dat_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL merge: c2=%h valid=%b, required 3ffff/1", c2, dat_valid);
        end
        tests_run++;
        if (c4 !== m_active[4] || c0 !== m_active[0]) begin
            tests_failed++;
            $display("[TB] FAIL merge_others: c4=%h c0=%h, required %h/%h", c4, c0, m_active[4], m_active[0]);
        end
    endtask

    task automatic test_err();
        bit bad = 1'b0;
        tick(1'b1, 3'd7, 18'h12345, 1'b0);
        tests_run++;
        if (err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL err_set: err=%b, required 1", err);
        end
        tick(1'b0, 3'd0, 18'd0, 1'b1);
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL err_clear: err=%b, required 0", err);
        end
        for (int i = 0; i < 1 + FLUSH; i++) begin
            tests_run++;
            if (wr_ready !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL flush_ready cycle %0d: ready=%b, required 0", i, wr_ready);
            end
            tick(1'b1, 3'($urandom_range(0, 6)), 18'($urandom), 1'b0);
        end
        tick(1'b0, 3'd0, 18'd0, 1'b1);
        for (int i = 0; i < 1 + FLUSH; i++) tick(1'b0, 3'd0, 18'd0, 1'b0);
        for (int i = 0; i < 7; i++) if (dut_coeff[i] !== m_active[i]) bad = 1'b1;
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("[TB] FAIL err_no_write: got %h, required %h", {c6, c5, c4, c3, c2, c1, c0},
                     {m_active[6], m_active[5], m_active[4], m_active[3], m_active[2], m_active[1], m_active[0]});
        end
    endtask

    task automatic test_reset_mid_flush();
        int ack_seen = 0;
        for (int i = 0; i < 7; i++) tick(1'b1, 3'(i), 18'($urandom) | 18'h1, 1'b0);
        tick(1'b0, 3'd0, 18'd0, 1'b1);
        for (int i = 0; i < 6; i++) tick(1'b0, 3'd0, 18'd0, 1'b0);
        #2 rst = 1'b1;
        model_reset();
        #1;
        tests_run++;
        if ({c0, c1, c2, c3, c4, c5, c6} !== 126'd0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_coeff: got %h, required 0", {c6, c5, c4, c3, c2, c1, c0});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < FLUSH; i++) begin
            tests_run++;
            if (busy !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL midflush_busy cycle %0d: busy=%b, required 1", i, busy);
            end
            if (commit_ack === 1'b1) ack_seen++;
            tick(1'b0, 3'd0, 18'd0, 1'b0);
        end
        tests_run++;
        if (ack_seen != 0 || dat_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midflush_end: acks=%0d valid=%b, required 0/1", ack_seen, dat_valid);
        end
        tick(1'b0, 3'd0, 18'd0, 1'b1);
        for (int i = 0; i < 1 + FLUSH; i++) tick(1'b0, 3'd0, 18'd0, 1'b0);
        tests_run++;
        if ({c0, c1, c2, c3, c4, c5, c6} !== 126'd0) begin
            tests_failed++;
            $display("[TB] FAIL shadow_lost: got %h, required 0", {c6, c5, c4, c3, c2, c1, c0});
        end
    endtask

`ifdef SEVENTAP_COEFF_SYMMETRIC_EN
    task automatic test_symmetric();
        tick(1'b1, 3'd1, 18'h00ABC, 1'b1);
        for (int i = 0; i < 1 + FLUSH; i++) tick(1'b0, 3'd0, 18'd0, 1'b0);
        tests_run++;
        if (c1 !== 18'h00ABC || c5 !== 18'h00ABC) begin
            tests_failed++;
            $display("[TB] FAIL sym_mirror: c1=%h c5=%h, required 00abc/00abc", c1, c5);
        end
        tick(1'b1, 3'd5, 18'h01234, 1'b0);
        tests_run++;
        if (err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL sym_err: err=%b, required 1", err);
        end
        tick(1'b0, 3'd0, 18'd0, 1'b1);
        for (int i = 0; i < 1 + FLUSH; i++) tick(1'b0, 3'd0, 18'd0, 1'b0);
        tests_run++;
        if (c5 !== 18'h00ABC || c1 !== 18'h00ABC) begin
            tests_failed++;
            $display("[TB] FAIL sym_unchanged: c1=%h c5=%h, required 00abc/00abc", c1, c5);
        end
    endtask
`endif

    task automatic test_random();
        bit bad;
        for (int n = 0; n < 400; n++) begin
            tick(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 18'($urandom),
                 1'($urandom_range(0, 7) == 0));
            bad = 1'b0;
            for (int i = 0; i < 7; i++) if (dut_coeff[i] !== m_active[i]) bad = 1'b1;
            tests_run++;
            if (bad) begin
                tests_failed++;
                $display("[TB] FAIL rand_coeff step %0d: got %h, required %h", n, {c6, c5, c4, c3, c2, c1, c0},
                         {m_active[6], m_active[5], m_active[4], m_active[3], m_active[2], m_active[1], m_active[0]});
            end
            tests_run++;
            if ({dat_valid, wr_ready, busy, commit_ack, err} !==
                {m_blank == 0, m_blank == 0, m_blank != 0, m_ack_armed && m_blank == 1, m_err}) begin
                tests_failed++;
                $display("[TB] FAIL rand_ctrl step %0d: valid/ready/busy/ack/err=%b%b%b%b%b, required %b%b%b%b%b",
                         n, dat_valid, wr_ready, busy, commit_ack, err,
                         m_blank == 0, m_blank == 0, m_blank != 0, m_ack_armed && m_blank == 1, m_err);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_write_commit();
        test_merge();
        test_err();
        test_reset_mid_flush();
`ifdef SEVENTAP_COEFF_SYMMETRIC_EN
        test_symmetric();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
